// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor with valid/ready flow control.
// The carry chain is cut into STAGES chunks, one chunk resolved per pipeline stage.
module pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output logic             zero
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  function automatic logic [CW:0] chunk_add(input logic [CW-1:0] x,
                                            input logic [CW-1:0] y,
                                            input logic          ci);
    return {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, ci};
  endfunction

  logic [WIDTH-1:0] a_p   [STAGES];
  logic [WIDTH-1:0] b_p   [STAGES];
  logic [WIDTH-1:0] s_p   [STAGES];
  logic             c_p   [STAGES];
  logic             vld_p [STAGES];
  logic [STAGES-1:0] adv;

  // A stage moves when it is empty or its successor moves; empty slots refill under a stall.
  always_comb begin
    logic go;
    go  = out_ready;
    adv = '0;
    for (int k = LAST; k >= 0; k--) begin
      go     = ~vld_p[k] | go;
      adv[k] = go;
    end
  end

  assign in_ready = adv[0] & ~reset;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] src_a, src_b, src_s, nxt_s;
    logic             src_c, src_v;
    logic [CW:0]      res;

    if (k == 0) begin : g_first
      // Stage 0 boundary: subtract is folded into an inverted operand plus forced carry-in.
      assign src_a = a;
      assign src_b = sub ? ~b : b;
      assign src_c = sub | carryin;
      assign src_s = '0;
      assign src_v = in_valid & in_ready;
    end else begin : g_next
      // Stage k boundary: carry and partial sum arrive registered from stage k-1.
      assign src_a = a_p[k-1];
      assign src_b = b_p[k-1];
      assign src_c = c_p[k-1];
      assign src_s = s_p[k-1];
      assign src_v = vld_p[k-1];
    end

    assign res = chunk_add(src_a[k*CW +: CW], src_b[k*CW +: CW], src_c);

    always_comb begin
      nxt_s              = src_s;
      nxt_s[k*CW +: CW]  = res[CW-1:0];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_p[k] <= 1'b0;
      end else if (adv[k]) begin
        vld_p[k] <= src_v;
      end
    end

    always_ff @(posedge clk) begin
      if (adv[k] && src_v) begin
        a_p[k] <= src_a;
        b_p[k] <= src_b;
        s_p[k] <= nxt_s;
        c_p[k] <= res[CW];
      end
    end
  end

  // Output boundary: results are forced to zero whenever nothing is presented.
  assign out_valid = vld_p[LAST];
  assign sum       = out_valid ? s_p[LAST] : '0;
  assign carryout  = out_valid & c_p[LAST];
  assign overflow  = out_valid & (a_p[LAST][WIDTH-1] == b_p[LAST][WIDTH-1])
                               & (s_p[LAST][WIDTH-1] != a_p[LAST][WIDTH-1]);
  assign zero      = out_valid & (s_p[LAST] == '0);

endmodule

// File: tb/tb_pipe_addsub.sv
// Scoreboard bench for pipe_addsub over four (WIDTH,STAGES) configurations in parallel.
module tb_pipe_addsub;

  logic clk;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic to_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired, required the DUT event", nm);
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g_cfg
    localparam int W = (gi == 0) ? 32 : (gi == 1) ? 8 : (gi == 2) ? 32 : 64;
    localparam int S = (gi == 0) ? 2  : (gi == 1) ? 1 : (gi == 2) ? 4  : 2;

    logic         rst, in_valid, in_ready, carryin, sub;
    logic         out_valid, out_ready, carryout, overflow, zero;
    logic [W-1:0] a, b, sum;
    logic [W+2:0] q[$];
    logic         mon_en     = 1'b0;
    logic         prev_rst   = 1'b1;
    logic         stall_prev = 1'b0;
    logic [W+2:0] prev_out   = '0;
    int           cyc        = 0;
    int           last_cyc   = 0;
    int           b2b_left   = 0;

    pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (
      .clk(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .carryin(carryin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
      .carryout(carryout), .overflow(overflow), .zero(zero)
    );

    // Reference: plain integer arithmetic; returns {sum, carryout, overflow, zero}.
    function automatic logic [W+2:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic ci, input logic sb);
      logic [127:0]        ua, ub, ur;
      logic signed [127:0] sa, sbv, sr, smax, smin;
      logic                co, ov;
      ua   = {{(128-W){1'b0}}, av};
      ub   = {{(128-W){1'b0}}, bv};
      sa   = $signed({{(128-W){av[W-1]}}, av});
      sbv  = $signed({{(128-W){bv[W-1]}}, bv});
      smax = (128'sd1 <<< (W-1)) - 128'sd1;
      smin = -(128'sd1 <<< (W-1));
      if (sb) begin
        ur = ua - ub;
        co = (ua >= ub);
        sr = sa - sbv;
      end else begin
        ur = ua + ub + {127'd0, ci};
        co = ur[W];
        sr = sa + sbv + $signed({127'd0, ci});
      end
      ov = (sr > smax) || (sr < smin);
      return {ur[W-1:0], co, ov, (ur[W-1:0] == '0)};
    endfunction

    function automatic logic [W-1:0] rnd_op();
      logic [63:0]  r;
      logic [W-1:0] v;
      r = {$urandom(), $urandom()};
      case ($urandom_range(0, 7))
        0:       v = '0;
        1:       v = '1;
        2:       begin v = '0; v[W-1] = 1'b1; end
        3:       begin v = '1; v[W-1] = 1'b0; end
        default: v = r[W-1:0];
      endcase
      return v;
    endfunction

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic ci, input logic sb);
      int n;
      n = 0;
      a = av; b = bv; carryin = ci; sub = sb; in_valid = 1'b1;
      forever begin
        @(negedge clk);
        if (in_ready) begin
          q.push_back(model(av, bv, ci, sb));
          break;
        end
        n++;
        if (n > 200) begin
          to_fail($sformatf("c%0d issue_accept", gi));
          break;
        end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
      n = 1;
      forever begin
        @(negedge clk);
        if (out_valid) break;
        n++;
        if (n > 50) begin
          to_fail($sformatf("c%0d wait_out_valid", gi));
          break;
        end
      end
    endtask

    task automatic wait_drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 500) begin
        @(posedge clk);
        n++;
      end
      #1;
      chk($sformatf("c%0d drain_queue_empty", gi), 128'(q.size()), 128'(0));
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
      if (mon_en) begin
        if (!out_valid)
          chk($sformatf("c%0d idle_outputs_zero", gi),
              128'({sum, carryout, overflow, zero}), 128'(0));
        if (stall_prev && !prev_rst) begin
          chk($sformatf("c%0d stall_hold_valid", gi), 128'(out_valid), 128'(1));
          chk($sformatf("c%0d stall_hold_data", gi),
              128'({sum, carryout, overflow, zero}), 128'(prev_out));
        end
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL c%0d unexpected_result: got sum 0x%0h, required no output", gi, sum);
          end else begin
            chk($sformatf("c%0d result {sum,co,ov,z}", gi),
                128'({sum, carryout, overflow, zero}), 128'(q.pop_front()));
            if (b2b_left > 0) begin
              if (b2b_left < 8)
                chk($sformatf("c%0d b2b_gap", gi), 128'(cyc - last_cyc), 128'(1));
              b2b_left--;
            end
            last_cyc = cyc;
          end
        end
        stall_prev = out_valid && !out_ready;
        prev_out   = {sum, carryout, overflow, zero};
      end
      prev_rst = rst;
    end

    initial begin
      int           lat, acc;
      logic         pend;
      logic [W-1:0] msb_v;
      logic [W+2:0] e;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; carryin = 1'b0; sub = 1'b0;
      msb_v = '0; msb_v[W-1] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("c%0d reset_in_ready", gi), 128'(in_ready), 128'(0));
      rst = 1'b0;
      #1;
      chk($sformatf("c%0d post_reset_in_ready", gi), 128'(in_ready), 128'(1));
      chk($sformatf("c%0d post_reset_outputs", gi),
          128'({out_valid, sum, carryout, overflow, zero}), 128'(0));
      mon_en = 1'b1;

      // All-ones plus one wraps to zero with carry out.
      issue('1, W'(1), 1'b0, 1'b0);
      wait_out(lat);
      chk($sformatf("c%0d latency", gi), 128'(lat), 128'(S));
      e = {W'(0), 1'b1, 1'b0, 1'b1};
      chk($sformatf("c%0d wrap_add {sum,co,ov,z}", gi),
          128'({sum, carryout, overflow, zero}), 128'(e));
      @(posedge clk); #1;

      // Most negative minus one overflows to most positive.
      issue(msb_v, W'(1), 1'b0, 1'b1);
      wait_out(lat);
      e = {~msb_v, 1'b1, 1'b1, 1'b0};
      chk($sformatf("c%0d min_minus_one {sum,co,ov,z}", gi),
          128'({sum, carryout, overflow, zero}), 128'(e));
      @(posedge clk); #1;
      wait_drain();

      // Eight back-to-back operations, carryin=1 throughout.
      b2b_left = 8;
      for (int i = 0; i < 8; i++) issue(rnd_op(), rnd_op(), 1'b1, 1'(i % 2));
      wait_drain();
      chk($sformatf("c%0d b2b_all_seen", gi), 128'(b2b_left), 128'(0));

      // Downstream stall with continuous offers.
      out_ready = 1'b0; acc = 0; pend = 1'b0;
      for (int c = 0; c < 5; c++) begin
        if (!pend) begin
          a = rnd_op(); b = rnd_op();
          carryin = 1'($urandom()); sub = 1'($urandom());
          pend = 1'b1;
        end
        in_valid = 1'b1;
        @(negedge clk);
        if (in_ready) begin
          q.push_back(model(a, b, carryin, sub));
          acc++;
          pend = 1'b0;
        end
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      #1;
      chk($sformatf("c%0d stall_accepted", gi), 128'(acc), 128'(S));
      chk($sformatf("c%0d stall_in_ready", gi), 128'(in_ready), 128'(0));
      out_ready = 1'b1;
      wait_drain();

      // Reset with a full pipeline and an offer during reset.
      out_ready = 1'b0;
      for (int i = 0; i < S; i++) issue(rnd_op(), rnd_op(), 1'b1, 1'b0);
      rst = 1'b1; a = rnd_op(); b = rnd_op(); carryin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      #1;
      chk($sformatf("c%0d reset_cycle_in_ready", gi), 128'(in_ready), 128'(0));
      @(posedge clk); #1;
      q.delete();
      rst = 1'b0; in_valid = 1'b0;
      #1;
      chk($sformatf("c%0d flush_outputs", gi),
          128'({out_valid, sum, carryout, overflow, zero}), 128'(0));
      chk($sformatf("c%0d flush_in_ready", gi), 128'(in_ready), 128'(1));
      out_ready = 1'b1;
      repeat (S + 3) @(posedge clk);
      #1;
      issue(rnd_op(), rnd_op(), 1'b1, 1'b0);
      wait_drain();

      // Random traffic on both handshakes.
      pend = 1'b0;
      for (int c = 0; c < 400; c++) begin
        out_ready = ($urandom_range(0, 9) < 7);
        if (!pend && $urandom_range(0, 9) < 7) begin
          a = rnd_op(); b = rnd_op();
          carryin = 1'($urandom()); sub = 1'($urandom());
          pend = 1'b1;
        end
        in_valid = pend;
        @(negedge clk);
        if (in_valid && in_ready) begin
          q.push_back(model(a, b, carryin, sub));
          pend = 1'b0;
        end
        @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      wait_drain();
      done_cnt++;
    end
  end

  initial begin
    int n;
    n = 0;
    while (done_cnt < 4 && n < 30000) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt < 4) begin
      n_checks++;
      n_fail++;
      $display("FAIL run_timeout: %0d configurations finished, required 4", done_cnt);
    end
    @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits; legal values 8..64.
REQ-002 Parameter: STAGES, default 2, pipeline depth; legal values 1..4; WIDTH SHALL be divisible by STAGES.
REQ-003 Port: clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port: in_valid  input  1  upstream presents an operation.
REQ-006 Port: in_ready  output  1  block accepts the operation this cycle.
REQ-007 Port: a  input  WIDTH  operand X.
REQ-008 Port: b  input  WIDTH  operand Y.
REQ-009 Port: carryin  input  1  carry-in for add mode.
REQ-010 Port: sub  input  1  0 = add, 1 = subtract.
REQ-011 Port: out_valid  output  1  result presented downstream.
REQ-012 Port: out_ready  input  1  downstream accepts the result.
REQ-013 Port: sum  output  WIDTH  result.
REQ-014 Port: carryout  output  1  carry out of the MSB (borrow-not in subtract mode).
REQ-015 Port: overflow  output  1  signed two's-complement overflow.
REQ-016 Port: zero  output  1  high when sum == 0.

Function
REQ-017 Add mode SHALL compute {carryout,sum} = a + b + carryin, modulo 2^(WIDTH+1).
REQ-018 Subtract mode SHALL compute a + ~b + 1; carryin is ignored when sub = 1.
REQ-019 overflow SHALL be (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), where b_eff = b in add mode and ~b in subtract mode.
REQ-020 The datapath SHALL be split into STAGES chunks of WIDTH/STAGES bits, least-significant chunk first.
REQ-021 Stage k SHALL compute chunk k and register it together with the carry into chunk k+1 and the unprocessed upper operand bits.
REQ-022 No combinational carry path SHALL span more than one chunk.
REQ-023 A transfer in SHALL occur when in_valid && in_ready; a transfer out SHALL occur when out_valid && out_ready.
REQ-024 Latency SHALL be exactly STAGES cycles from the accepting edge to out_valid when no stall occurs.
REQ-025 Each stage SHALL hold a valid bit, and a stage SHALL advance when it is empty or the next stage advances; the last stage advances on out_ready.
REQ-026 in_ready SHALL be high when stage 0 can advance, giving bubble collapse: the pipeline refills empty slots while downstream stalls.
REQ-027 Throughput SHALL be one operation per cycle while out_ready is held high.
REQ-028 While out_valid && !out_ready, sum, carryout, overflow and zero SHALL hold stable.
REQ-029 Operations SHALL leave the block in acceptance order, with none dropped or duplicated.
REQ-030 Simultaneous transfer in and transfer out on a full pipeline SHALL be legal and SHALL preserve occupancy.
REQ-031 When out_valid = 0, sum, carryout, overflow and zero SHALL be 0.

Reset
REQ-032 On reset, all stage valid bits SHALL clear, so out_valid = 0 and sum, carryout, overflow and zero = 0 on the following cycle.
REQ-033 Reset mid-operation SHALL discard all in-flight operations; none SHALL emerge after reset deasserts.
REQ-034 in_ready SHALL be 0 during the reset cycle and 1 on the first cycle after reset deasserts.
REQ-035 in_valid asserted together with reset SHALL NOT be accepted.

Verification
REQ-036 Case: WIDTH=32, STAGES=2, add 0xFFFFFFFF + 0x00000001, carryin=0 -> two cycles later sum=0, carryout=1, zero=1, overflow=0.
REQ-037 Case: sub with a=0x80000000, b=0x00000001 -> sum=0x7FFFFFFF, overflow=1, carryout=1.
REQ-038 Case: 8 back-to-back ops with out_ready=1 -> 8 results on consecutive cycles, in order, each matching the reference model.
REQ-039 Case: hold out_ready=0 for 5 cycles while in_valid=1 -> exactly STAGES ops accepted, in_ready=0 afterwards, outputs stable; releasing out_ready drains all in order.
REQ-040 Case: assert reset with the pipeline full -> out_valid=0 next cycle, no stale result appears, the next accepted op completes correctly.
REQ-041 Case: random sweep across (WIDTH,STAGES) in {(8,1),(32,4),(64,2)} with random in_valid/out_ready -> scoreboard shows zero mismatches, including add with carryin=1.
